button_debounce: RTL

Debounces one mechanical push-button on the LX9 board and turns it into clean, synchronous control events in the `clk_12m` domain. It is the input-side counterpart of the LED drivers: raw pad in, debounced level plus single-cycle press, release and long-press pulses out, along with a running press counter. One instance is placed per board button, between the pad and the top-level logic.

---
 rtl/board_io_pkg.sv | 15 +
 rtl/sync2.sv | 23 ++
 rtl/button_debounce.sv | 125 ++++++++++++
 3 files changed

// File: rtl/board_io_pkg.sv
// Shared definitions for the LX9 board I/O blocks: debounce FSM encoding
// and constants derived from the 12 MHz system clock.
package board_io_pkg;

    typedef logic [1:0] btn_state_t;

    localparam btn_state_t IDLE         = 2'd0;
    localparam btn_state_t PRESS_WAIT   = 2'd1;
    localparam btn_state_t PRESSED      = 2'd2;
    localparam btn_state_t RELEASE_WAIT = 2'd3;

    localparam int DEBOUNCE_10MS = 120000;
    localparam int LONG_1S       = 12000000;

endpackage

// File: rtl/sync2.sv
// Reusable two-flop synchronizer with asynchronous reset to a chosen level.
module sync2 #(
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer: synchronized pad in, debounced level, press/release/long
// pulses and a wrapping press counter out. Long-press detection is built only
// when BUTTON_LONG_PRESS_EN is defined.
module button_debounce
    import board_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int LONG_CYCLES     = LONG_1S,
    parameter int CNT_W           = 24,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic       clk_12m,
    input  logic       rst,
    input  logic       btn_raw,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic [7:0] press_count
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    btn_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             btn_s;

    // Synchronizer output resets to "released" so a held button is seen as a new press.
    sync2 #(.RESET_VAL(1'b0)) u_sync (
        .clk (clk_12m),
        .rst (rst),
        .d   (btn_raw ^ ACTIVE_LOW),
        .q   (btn_s)
    );

`ifdef BUTTON_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    logic long_done;
`else
    logic unused_long_cfg;
    assign unused_long_cfg = ^LONG_CYCLES;
    assign long_pulse = 1'b0;
`endif

    always_ff @(posedge clk_12m or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            press_count   <= '0;
`ifdef BUTTON_LONG_PRESS_EN
            long_pulse    <= 1'b0;
            long_done     <= 1'b0;
`endif
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
`ifdef BUTTON_LONG_PRESS_EN
            long_pulse    <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (btn_s) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_s) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state       <= PRESSED;
                        cnt         <= '0;
                        press_pulse <= 1'b1;
                        btn_level   <= 1'b1;
                        press_count <= press_count + 8'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!btn_s) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
`ifdef BUTTON_LONG_PRESS_EN
                    // Counter parks at the last value so the pulse can fire only once.
                    else if (cnt == LONG_LAST) begin
                        if (!long_done) begin
                            long_pulse <= 1'b1;
                            long_done  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                RELEASE_WAIT: begin
                    if (btn_s) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state         <= IDLE;
                        cnt           <= '0;
                        release_pulse <= 1'b1;
                        btn_level     <= 1'b0;
`ifdef BUTTON_LONG_PRESS_EN
                        long_done     <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
